// File: rtl/teamplayer_io.sv
// teamplayer_io: Sega Team Player 4-way multitap responder for one controller port.
// Watches the port's effective TH/TR levels; a TH fall starts a packet and each
// stable TR toggle is acknowledged on TL while a nibble stream is walked:
// ID, pad types, then active-low button data of every present pad.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   CE                    clock enable for all state
//   PAD_EN, PAD_6B        pad present / pad is 6-button, bit0 = pad A
//   PA_BTN..PD_BTN        pressed=1, {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}
//   TH, TR                effective port TH/TR levels
//   DO                    port read value {0, TH, TR, TL, NIB}
//   ACTIVE                packet in progress
module teamplayer_io #(
  parameter int unsigned ACK_DLY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic [3:0]  PAD_EN,
  input  logic [3:0]  PAD_6B,
  input  logic [11:0] PA_BTN,
  input  logic [11:0] PB_BTN,
  input  logic [11:0] PC_BTN,
  input  logic [11:0] PD_BTN,
  input  logic        TH,
  input  logic        TR,
  output logic [7:0]  DO,
  output logic        ACTIVE
);

  localparam int unsigned IDX_W     = 5;
  localparam int unsigned DLY_W     = 4;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BTN_W     = 12;
  localparam int unsigned NPAD      = 4;
  localparam int unsigned DATA_BASE = 7;

  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(31);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ACK_DLY - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, nxt_state;
  logic [IDX_W-1:0]   idx, nxt_idx;
  logic               ack, nxt_ack;
  logic [DLY_W-1:0]   dly, nxt_dly;
  logic               thd;
  logic               snap;

  logic [NPAD-1:0]    s_en, s_6b;
  logic [BTN_W-1:0]   s_btn [NPAD];

  logic [NIB_W-1:0]   stream_nib;
  logic [NIB_W-1:0]   nib;

  // Data nibble k of one pad: directions, then START/A/C/B, then MODE/X/Y/Z.
  function automatic logic [NIB_W-1:0] data_nib(input logic [BTN_W-1:0] b,
                                                input logic [1:0] k);
    logic [NIB_W-1:0] n;
    case (k)
      2'd0:    n = ~b[3:0];
      2'd1:    n = ~{b[7], b[4], b[6], b[5]};
      default: n = ~{b[8], b[9], b[10], b[11]};
    endcase
    return n;
  endfunction

  // State register, handshake counters and packet snapshot.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      idx   <= '0;
      ack   <= 1'b1;
      dly   <= '0;
      thd   <= 1'b1;
      s_en  <= '0;
      s_6b  <= '0;
      for (int p = 0; p < NPAD; p++) s_btn[p] <= '0;
    end else if (CE) begin
      state <= nxt_state;
      idx   <= nxt_idx;
      ack   <= nxt_ack;
      dly   <= nxt_dly;
      thd   <= TH;
      if (snap) begin
        s_en     <= PAD_EN;
        s_6b     <= PAD_6B;
        s_btn[0] <= PA_BTN;
        s_btn[1] <= PB_BTN;
        s_btn[2] <= PC_BTN;
        s_btn[3] <= PD_BTN;
      end
    end
  end

  // Next-state: packet start on TH fall, TR handshake with debounce, TH abort.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_ack   = ack;
    nxt_dly   = dly;
    snap      = 1'b0;
    case (state)
      IDLE: begin
        if (thd && !TH) begin
          nxt_state = XFER;
          nxt_idx   = '0;
          nxt_ack   = TR;
          nxt_dly   = '0;
          snap      = 1'b1;
        end
      end
      XFER: begin
        if (TH) begin
          // TH rise aborts even on the cycle a handshake would complete.
          nxt_state = IDLE;
          nxt_idx   = '0;
          nxt_ack   = 1'b1;
          nxt_dly   = '0;
        end else if (TR != ack) begin
          if (dly == DLY_LAST) begin
            nxt_ack = TR;
            nxt_idx = (idx == IDX_MAX) ? idx : idx + IDX_W'(1);
            nxt_dly = '0;
          end else begin
            nxt_dly = dly + DLY_W'(1);
          end
        end else begin
          nxt_dly = '0;
        end
      end
    endcase
  end

  // Stream nibble at idx; pad data offsets come from a running sum of 0/2/3.
  always_comb begin
    logic [IDX_W-1:0] acc;
    logic [IDX_W-1:0] len;
    logic [1:0]       tp;
    stream_nib = 4'hF;
    acc        = IDX_W'(DATA_BASE);
    len        = '0;
    tp         = 2'(idx - IDX_W'(3));
    if (idx == IDX_W'(0)) begin
      stream_nib = 4'hF;
    end else if (idx < IDX_W'(3)) begin
      stream_nib = 4'h0;
    end else if (idx < IDX_W'(DATA_BASE)) begin
      stream_nib = !s_en[tp] ? 4'hF : (s_6b[tp] ? 4'h1 : 4'h0);
    end else begin
      for (int p = 0; p < NPAD; p++) begin
        len = !s_en[p] ? IDX_W'(0) : (s_6b[p] ? IDX_W'(3) : IDX_W'(2));
        if (s_en[p] && (idx >= acc) && (idx < acc + len))
          stream_nib = data_nib(s_btn[p], 2'(idx - acc));
        acc = acc + len;
      end
    end
  end

  assign nib    = (state == XFER) ? stream_nib : 4'h3;
  assign DO     = {1'b0, TH, TR, ack, nib};
  assign ACTIVE = (state == XFER);

endmodule

// File: tb/tb_teamplayer_io.sv
// tb_teamplayer_io: directed and random stimulus for teamplayer_io, checked
// every clock against a queue-based model of the Team Player nibble stream.
module tb_teamplayer_io;

  localparam int unsigned ACK_DLY = 4;

  logic        CLK = 1'b0;
  logic        RESET, CE, TH, TR;
  logic [3:0]  PAD_EN, PAD_6B;
  logic [11:0] btn [4];
  logic [7:0]  DO;
  logic        ACTIVE;

  int errors = 0;
  int checks = 0;
  int r;
  logic [7:0] saved;

  // Reference model state
  bit         m_active;
  int         m_idx;
  bit         m_ack;
  int         m_cnt;
  bit         m_thd;
  logic [3:0] m_stream [$];

  logic [3:0] exp_l [0:14] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h1, 4'hF,
                               4'hE, 4'h7, 4'hF, 4'hF, 4'hB, 4'hF, 4'hF, 4'hF};

  teamplayer_io #(.ACK_DLY(ACK_DLY)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .PAD_EN(PAD_EN), .PAD_6B(PAD_6B),
    .PA_BTN(btn[0]), .PB_BTN(btn[1]), .PC_BTN(btn[2]), .PD_BTN(btn[3]),
    .TH(TH), .TR(TR), .DO(DO), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  function void build_stream();
    logic [11:0] b;
    m_stream.delete();
    m_stream.push_back(4'hF);
    m_stream.push_back(4'h0);
    m_stream.push_back(4'h0);
    for (int p = 0; p < 4; p++)
      m_stream.push_back(!PAD_EN[p] ? 4'hF : (PAD_6B[p] ? 4'h1 : 4'h0));
    for (int p = 0; p < 4; p++) begin
      if (PAD_EN[p]) begin
        b = btn[p];
        m_stream.push_back(~{b[3], b[2], b[1], b[0]});
        m_stream.push_back(~{b[7], b[4], b[6], b[5]});
        if (PAD_6B[p]) m_stream.push_back(~{b[8], b[9], b[10], b[11]});
      end
    end
  endfunction

  function void model_update();
    if (RESET) begin
      m_active = 1'b0; m_idx = 0; m_ack = 1'b1; m_cnt = 0; m_thd = 1'b1;
      m_stream.delete();
    end else if (CE) begin
      if (!m_active) begin
        if (m_thd && !TH) begin
          m_active = 1'b1; m_idx = 0; m_ack = TR; m_cnt = 0;
          build_stream();
        end
      end else if (TH) begin
        m_active = 1'b0; m_idx = 0; m_ack = 1'b1; m_cnt = 0;
      end else if (TR != m_ack) begin
        m_cnt++;
        if (m_cnt >= ACK_DLY) begin
          m_ack = TR;
          if (m_idx < 31) m_idx++;
          m_cnt = 0;
        end
      end else begin
        m_cnt = 0;
      end
      m_thd = TH;
    end
  endfunction

  function logic [3:0] exp_nib();
    if (!m_active) return 4'h3;
    if (m_idx < m_stream.size()) return m_stream[m_idx];
    return 4'hF;
  endfunction

  function logic [7:0] exp_do();
    return {1'b0, TH, TR, m_ack, exp_nib()};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    check("do", DO, exp_do());
    check("active", {7'd0, ACTIVE}, {7'd0, m_active});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic advance(input logic [3:0] want, input string tag);
    TR = ~TR;
    steps(ACK_DLY);
    check(tag, {4'h0, DO[3:0]}, {4'h0, want});
    check("tl_follow", {7'd0, DO[4]}, {7'd0, TR});
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1; TH = 1'b1; TR = 1'b1;
    PAD_EN = 4'h0; PAD_6B = 4'h0;
    for (int p = 0; p < 4; p++) btn[p] = 12'h000;
    steps(2);
    RESET = 1'b0;
    step();
    check("reset_do", DO, 8'h73);
    check("reset_active", {7'd0, ACTIVE}, 8'h00);

    // Basic handshake with no pads
    TH = 1'b0;
    step();
    check("first_nib", DO, 8'h3F);
    TR = 1'b0;
    #1 check("tr_comb", DO, 8'h1F);
    steps(ACK_DLY - 1);
    check("ack_wait", DO, 8'h1F);
    step();
    check("ack_l1", DO, 8'h00);
    TR = 1'b1;
    steps(ACK_DLY);
    check("ack_l2", DO, 8'h30);
    TH = 1'b1;
    step();
    check("th_exit", DO, 8'h73);

    // Mixed pads; buttons change mid-packet but snapshot holds
    PAD_EN = 4'b0101; PAD_6B = 4'b0100;
    btn[0] = 12'h081; btn[2] = 12'h200;
    TH = 1'b0;
    step();
    check("pkt2_l0", DO, 8'h3F);
    btn[0] = 12'hFFF;
    for (int i = 1; i <= 6; i++) advance(exp_l[i], "walk");
    // Short TR pulse must not acknowledge
    saved = DO;
    TR = ~TR; steps(2); TR = ~TR; steps(2);
    check("pulse_hold", {3'd0, DO[4:0]}, {3'd0, saved[4:0]});
    for (int i = 7; i <= 9; i++) advance(exp_l[i], "walk_after_pulse");
    // TH rise mid-handshake at idx 9
    TR = ~TR; steps(2);
    TH = 1'b1;
    step();
    check("mid_abort", DO, {1'b0, 1'b1, TR, 1'b1, 4'h3});

    // Fresh packet: new snapshot sees pad A all pressed
    TH = 1'b0;
    step();
    check("pkt3_l0", {4'h0, DO[3:0]}, 8'h0F);
    // CE low freezes state while DO still tracks TR
    CE = 1'b0;
    saved = DO;
    TR = ~TR;
    steps(6);
    check("ce_hold", {4'h0, DO[3:0]}, {4'h0, saved[3:0]});
    check("ce_tr", {7'd0, DO[5]}, {7'd0, TR});
    CE = 1'b1;
    steps(ACK_DLY);
    check("ce_resume", {4'h0, DO[3:0]}, 8'h00);
    for (int i = 2; i <= 6; i++) advance(exp_l[i], "walk3");
    advance(4'h0, "padA_dir_all");
    advance(4'h0, "padA_btn_all");
    advance(4'hF, "padC_0");
    advance(4'hF, "padC_1");
    advance(4'hB, "padC_x");
    for (int i = 12; i < 40; i++) advance(4'hF, "saturate");
    RESET = 1'b1;
    step();
    check("rst_mid", DO, {1'b0, TH, TR, 1'b1, 4'h3});
    check("rst_active", {7'd0, ACTIVE}, 8'h00);
    // TH fall while in reset does not start a packet
    TH = 1'b1; step(); TH = 1'b0; step();
    check("rst_th_fall", {7'd0, ACTIVE}, 8'h00);
    RESET = 1'b0;
    TH = 1'b1;
    steps(2);

    // Random packets
    for (int p = 0; p < 6; p++) begin
      PAD_EN = 4'($urandom); PAD_6B = 4'($urandom);
      for (int q = 0; q < 4; q++) btn[q] = 12'($urandom);
      TR = 1'($urandom);
      step();
      TH = 1'b0;
      step();
      for (int n = 0; n < 160; n++) begin
        CE = ($urandom_range(0, 9) < 8);
        r = $urandom_range(0, 39);
        if (r < 8) TR = ~TR;
        else if (r == 8) btn[$urandom_range(0, 3)] = 12'($urandom);
        else if (r == 9) TH = ~TH;
        step();
      end
      CE = 1'b1;
      TH = 1'b1;
      steps(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
